// File: rtl/ddr_init_seq.sv
// ECP5 DDR CRG bring-up sequencer plus runtime DLL code-update arbiter (clkin domain).
// Latency: outputs registered, they change in the first cycle a state is occupied; dll_lock is seen 2 cycles late.
// Backpressure: upd_req is a level, sampled only in RUN; held requests are serviced back to back, one upd_ack each.
module ddr_init_seq #(
  parameter int LOCK_FILTER   = 16,
  parameter int RST_CYCLES    = 8,
  parameter int STOP_CYCLES   = 8,
  parameter int UPDATE_CYCLES = 4,
  parameter int PAUSE_CYCLES  = 4
) (
  input  logic clkin,
  input  logic rst_n,
  input  logic pll_lock,
  input  logic dll_lock,
  input  logic upd_req,
  output logic upd_ack,
  output logic eclk_stop,
  output logic div_rst,
  output logic dll_rst,
  output logic dll_uddcntln,
  output logic dqs_pause,
  output logic sync_rst,
  output logic init
);

  // One shared down-counter; it must hold the largest load value.
  localparam int MAX_A = (LOCK_FILTER > RST_CYCLES) ? LOCK_FILTER : RST_CYCLES;
  localparam int MAX_B = (STOP_CYCLES > UPDATE_CYCLES) ? STOP_CYCLES : UPDATE_CYCLES;
  localparam int MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int MAXP  = (MAX_C > PAUSE_CYCLES) ? MAX_C : PAUSE_CYCLES;
  localparam int CW    = (MAXP > 1) ? $clog2(MAXP + 1) : 1;

  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [CW-1:0] LF_LOAD    = CW'(LOCK_FILTER - 1);
  localparam logic [CW-1:0] RST_LOAD   = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] STOP_LOAD  = CW'(STOP_CYCLES - 1);
  localparam logic [CW-1:0] UPD_LOAD   = CW'(UPDATE_CYCLES - 1);
  localparam logic [CW-1:0] PAUSE_LOAD = CW'(PAUSE_CYCLES - 1);

  typedef enum logic [3:0] {
    S_WAIT_LOCK  = 4'd0,
    S_FILTER     = 4'd1,
    S_DIV_RST    = 4'd2,
    S_STOP_HOLD  = 4'd3,
    S_DLL_WAIT   = 4'd4,
    S_UPDATE     = 4'd5,
    S_RUN        = 4'd6,
    S_PAUSE_PRE  = 4'd7,
    S_PAUSE_UPD  = 4'd8,
    S_PAUSE_POST = 4'd9
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          dll_meta_q, dll_meta_d;
  logic          dll_sync_q, dll_sync_d;
  logic          upd_ack_q, upd_ack_d;
  logic          eclk_stop_q, eclk_stop_d;
  logic          div_rst_q, div_rst_d;
  logic          dll_rst_q, dll_rst_d;
  logic          dll_uddcntln_q, dll_uddcntln_d;
  logic          dqs_pause_q, dqs_pause_d;
  logic          sync_rst_q, sync_rst_d;
  logic          init_q, init_d;

  logic cnt_zero;
  logic dll_watch;
  logic lock_fail;

  assign cnt_zero  = (cnt_q == '0);
  // DLL lock only matters once the controller owns the interface.
  assign dll_watch = (state_q == S_RUN) || (state_q == S_PAUSE_PRE) ||
                     (state_q == S_PAUSE_UPD) || (state_q == S_PAUSE_POST);
  assign lock_fail = ((state_q != S_WAIT_LOCK) && !pll_lock) ||
                     (dll_watch && !dll_sync_q);

  // Two-flop synchroniser for the DDRDLL lock indication.
  always_comb begin
    dll_meta_d = dll_lock;
    dll_sync_d = dll_meta_q;
  end

  // Next state, counter reload/decrement and the update-done pulse.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    upd_ack_d = 1'b0;
    unique case (state_q)
      S_WAIT_LOCK: begin
        if (pll_lock) begin
          state_d = S_FILTER;
          cnt_d   = LF_LOAD;
        end
      end
      S_FILTER: begin
        if (cnt_zero) begin
          state_d = S_DIV_RST;
          cnt_d   = RST_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_DIV_RST: begin
        if (cnt_zero) begin
          state_d = S_STOP_HOLD;
          cnt_d   = STOP_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_STOP_HOLD: begin
        if (cnt_zero) begin
          state_d = S_DLL_WAIT;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_DLL_WAIT: begin
        if (dll_sync_q) begin
          state_d = S_UPDATE;
          cnt_d   = UPD_LOAD;
        end
      end
      S_UPDATE: begin
        if (cnt_zero) begin
          state_d = S_RUN;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_RUN: begin
        if (upd_req) begin
          state_d = S_PAUSE_PRE;
          cnt_d   = PAUSE_LOAD;
        end
      end
      S_PAUSE_PRE: begin
        if (cnt_zero) begin
          state_d = S_PAUSE_UPD;
          cnt_d   = UPD_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_PAUSE_UPD: begin
        if (cnt_zero) begin
          state_d = S_PAUSE_POST;
          cnt_d   = PAUSE_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_PAUSE_POST: begin
        if (cnt_zero) begin
          state_d   = S_RUN;
          upd_ack_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = S_WAIT_LOCK;
        cnt_d   = '0;
      end
    endcase
    // Any lock loss aborts everything, including an in-flight update (no ack).
    if (lock_fail) begin
      state_d   = S_WAIT_LOCK;
      cnt_d     = '0;
      upd_ack_d = 1'b0;
    end
  end

  // Output levels decoded from the upcoming state so they register alongside it.
  always_comb begin
    eclk_stop_d    = 1'b1;
    div_rst_d      = 1'b1;
    dll_rst_d      = 1'b1;
    dll_uddcntln_d = 1'b1;
    dqs_pause_d    = 1'b1;
    sync_rst_d     = 1'b1;
    init_d         = 1'b0;
    unique case (state_d)
      S_WAIT_LOCK, S_FILTER, S_DIV_RST: begin
      end
      S_STOP_HOLD: begin
        div_rst_d = 1'b0;
        dll_rst_d = 1'b0;
      end
      S_DLL_WAIT: begin
        eclk_stop_d = 1'b0;
        div_rst_d   = 1'b0;
        dll_rst_d   = 1'b0;
      end
      S_UPDATE: begin
        eclk_stop_d    = 1'b0;
        div_rst_d      = 1'b0;
        dll_rst_d      = 1'b0;
        dll_uddcntln_d = 1'b0;
      end
      S_RUN: begin
        eclk_stop_d = 1'b0;
        div_rst_d   = 1'b0;
        dll_rst_d   = 1'b0;
        dqs_pause_d = 1'b0;
        sync_rst_d  = 1'b0;
        init_d      = 1'b1;
      end
      S_PAUSE_PRE, S_PAUSE_POST: begin
        eclk_stop_d = 1'b0;
        div_rst_d   = 1'b0;
        dll_rst_d   = 1'b0;
        sync_rst_d  = 1'b0;
        init_d      = 1'b1;
      end
      S_PAUSE_UPD: begin
        eclk_stop_d    = 1'b0;
        div_rst_d      = 1'b0;
        dll_rst_d      = 1'b0;
        dll_uddcntln_d = 1'b0;
        sync_rst_d     = 1'b0;
        init_d         = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // State, counter, synchroniser and registered outputs; reset forces the safe CRG levels.
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_WAIT_LOCK;
      cnt_q          <= '0;
      dll_meta_q     <= 1'b0;
      dll_sync_q     <= 1'b0;
      upd_ack_q      <= 1'b0;
      eclk_stop_q    <= 1'b1;
      div_rst_q      <= 1'b1;
      dll_rst_q      <= 1'b1;
      dll_uddcntln_q <= 1'b1;
      dqs_pause_q    <= 1'b1;
      sync_rst_q     <= 1'b1;
      init_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      dll_meta_q     <= dll_meta_d;
      dll_sync_q     <= dll_sync_d;
      upd_ack_q      <= upd_ack_d;
      eclk_stop_q    <= eclk_stop_d;
      div_rst_q      <= div_rst_d;
      dll_rst_q      <= dll_rst_d;
      dll_uddcntln_q <= dll_uddcntln_d;
      dqs_pause_q    <= dqs_pause_d;
      sync_rst_q     <= sync_rst_d;
      init_q         <= init_d;
    end
  end

  assign upd_ack      = upd_ack_q;
  assign eclk_stop    = eclk_stop_q;
  assign div_rst      = div_rst_q;
  assign dll_rst      = dll_rst_q;
  assign dll_uddcntln = dll_uddcntln_q;
  assign dqs_pause    = dqs_pause_q;
  assign sync_rst     = sync_rst_q;
  assign init         = init_q;

endmodule

// File: tb/tb_ddr_init_seq.sv
// Bench for ddr_init_seq: timeline reference model feeds a scoreboard of per-cycle output vectors.
// Latency: expectations are pushed at each clock edge and popped 1 time unit later.
// Backpressure: none; directed latency checks run alongside the scoreboard.
module tb_ddr_init_seq;

  localparam int LF = 16;
  localparam int RC = 8;
  localparam int SC = 8;
  localparam int UC = 4;
  localparam int PC = 4;
  localparam int BOOT_LEN  = LF + RC + SC;
  localparam int MAINT_LEN = 2 * PC + UC;

  // Vector bit order: eclk_stop div_rst dll_rst dll_uddcntln dqs_pause sync_rst init upd_ack
  localparam logic [7:0] RST_VEC  = 8'b1111_1100;
  localparam logic [7:0] STOP_VEC = 8'b1001_1100;
  localparam logic [7:0] DLLW_VEC = 8'b0001_1100;
  localparam logic [7:0] UPD_VEC  = 8'b0000_1100;

  localparam int P_WAIT  = 0;
  localparam int P_BOOT  = 1;
  localparam int P_DLLW  = 2;
  localparam int P_UPD   = 3;
  localparam int P_RUN   = 4;
  localparam int P_MAINT = 5;

  logic clkin    = 1'b0;
  logic rst_n    = 1'b0;
  logic pll_lock = 1'b0;
  logic dll_lock = 1'b0;
  logic upd_req  = 1'b0;
  logic upd_ack, eclk_stop, div_rst, dll_rst, dll_uddcntln, dqs_pause, sync_rst, init;
  logic [7:0] act_vec;

  assign act_vec = {eclk_stop, div_rst, dll_rst, dll_uddcntln, dqs_pause, sync_rst, init, upd_ack};

  always #5 clkin = ~clkin;

  ddr_init_seq #(
    .LOCK_FILTER(LF), .RST_CYCLES(RC), .STOP_CYCLES(SC),
    .UPDATE_CYCLES(UC), .PAUSE_CYCLES(PC)
  ) dut (
    .clkin(clkin), .rst_n(rst_n), .pll_lock(pll_lock), .dll_lock(dll_lock),
    .upd_req(upd_req), .upd_ack(upd_ack), .eclk_stop(eclk_stop), .div_rst(div_rst),
    .dll_rst(dll_rst), .dll_uddcntln(dll_uddcntln), .dqs_pause(dqs_pause),
    .sync_rst(sync_rst), .init(init)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  logic [7:0] exp_q[$];

  // Reference model: a boot timeline measured in elapsed cycles, not a copy of the state machine.
  int   ph = P_WAIT;
  int   e  = 0;
  logic dmeta = 1'b0;
  logic dsync = 1'b0;

  function automatic logic [7:0] expect_vec(input int p, input int el, input logic ack);
    logic [7:0] v;
    logic       udd;
    v = RST_VEC;
    case (p)
      P_BOOT:  v = (el >= LF + RC) ? STOP_VEC : RST_VEC;
      P_DLLW:  v = DLLW_VEC;
      P_UPD:   v = UPD_VEC;
      P_RUN:   v = {7'b0001001, ack};
      P_MAINT: begin
        udd = !((el >= PC) && (el < PC + UC));
        v = {3'b000, udd, 1'b1, 1'b0, 1'b1, 1'b0};
      end
      default: v = RST_VEC;
    endcase
    return v;
  endfunction

  task automatic model_step();
    logic ack;
    logic fail;
    ack = 1'b0;
    if (!rst_n) begin
      ph = P_WAIT; e = 0; dmeta = 1'b0; dsync = 1'b0;
    end else begin
      fail = ((ph != P_WAIT) && !pll_lock) || (((ph == P_RUN) || (ph == P_MAINT)) && !dsync);
      if (fail) begin
        ph = P_WAIT; e = 0;
      end else begin
        case (ph)
          P_WAIT:  if (pll_lock) begin ph = P_BOOT; e = 0; end
          P_BOOT:  if (e == BOOT_LEN - 1) ph = P_DLLW; else e++;
          P_DLLW:  if (dsync) begin ph = P_UPD; e = 0; end
          P_UPD:   if (e == UC - 1) ph = P_RUN; else e++;
          P_RUN:   if (upd_req) begin ph = P_MAINT; e = 0; end
          P_MAINT: if (e == MAINT_LEN - 1) begin ph = P_RUN; ack = 1'b1; end else e++;
          default: ph = P_WAIT;
        endcase
      end
      dsync = dmeta;
      dmeta = dll_lock;
    end
    exp_q.push_back(expect_vec(ph, e, ack));
  endtask

  // Stimulus side of the scoreboard: predict the next output vector at every edge.
  initial begin
    forever begin
      @(posedge clkin);
      model_step();
      cyc++;
    end
  end

  // Monitor: compare the presented outputs with the oldest prediction.
  initial begin
    logic [7:0] exp_v;
    forever begin
      @(posedge clkin);
      #1;
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        n_checks++;
        if (act_vec === exp_v) n_pass++;
        else $display("FAIL out_vec cycle %0d: got %b expected %b", cyc, act_vec, exp_v);
      end
    end
  end

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  // Count edges until a condition holds (0: init=1, 1: upd_ack=1, 2: init=0); -1 on timeout.
  task automatic wait_for(input int which, input int limit, output int n);
    logic hit;
    n = 0;
    forever begin
      @(posedge clkin);
      #1;
      n++;
      case (which)
        0:       hit = (init === 1'b1);
        1:       hit = (upd_ack === 1'b1);
        default: hit = (init === 1'b0);
      endcase
      if (hit) break;
      if (n >= limit) begin
        n = -1;
        break;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1);
  end

  initial begin
    int n;
    int acks;
    repeat (3) @(negedge clkin);
    check("reset_vec", int'(act_vec), int'(RST_VEC));
    rst_n = 1'b1;
    dll_lock = 1'b1;
    repeat (3) @(negedge clkin);

    // Power-up with DLL already locked.
    pll_lock = 1'b1;
    wait_for(0, 200, n);
    check("powerup_init_latency", n, BOOT_LEN + 1 + UC + 1);

    // Single runtime update, then a held request giving back-to-back acks.
    @(negedge clkin);
    upd_req = 1'b1;
    wait_for(1, 100, n);
    check("upd_ack_latency", n, MAINT_LEN + 1);
    wait_for(1, 100, n);
    check("b2b_ack_spacing", n, MAINT_LEN + 1);
    @(negedge clkin);
    upd_req = 1'b0;
    repeat (5) @(negedge clkin);
    check("init_after_updates", int'(init), 1);

    // Lock loss in the middle of the DLL update pulse.
    upd_req = 1'b1;
    repeat (PC + 2) @(posedge clkin);
    #1;
    check("in_pause_upd_uddcntln", int'(dll_uddcntln), 0);
    @(negedge clkin);
    pll_lock = 1'b0;
    upd_req = 1'b0;
    @(posedge clkin);
    #1;
    check("lockloss_init", int'(init), 0);
    check("lockloss_vec", int'(act_vec), int'(RST_VEC));
    acks = 0;
    repeat (20) begin
      @(posedge clkin);
      #1;
      if (upd_ack) acks++;
    end
    check("lockloss_no_ack", acks, 0);

    // Glitchy PLL lock restarts the filter.
    @(negedge clkin);
    pll_lock = 1'b1;
    repeat (10) @(negedge clkin);
    pll_lock = 1'b0;
    @(negedge clkin);
    pll_lock = 1'b1;
    wait_for(0, 200, n);
    check("glitch_init_latency", n, BOOT_LEN + 1 + UC + 1);

    // Late DLL lock: parked in DLL_WAIT with the ECLK running.
    @(negedge clkin);
    pll_lock = 1'b0;
    dll_lock = 1'b0;
    @(negedge clkin);
    pll_lock = 1'b1;
    repeat (BOOT_LEN + 102) @(negedge clkin);
    check("late_dll_eclk_stop", int'(eclk_stop), 0);
    check("late_dll_init", int'(init), 0);
    dll_lock = 1'b1;
    wait_for(0, 50, n);
    check("late_dll_init_latency", n, 2 + 1 + UC);

    // DLL lock loss while running.
    @(negedge clkin);
    dll_lock = 1'b0;
    wait_for(2, 20, n);
    check("dll_loss_latency", n, 3);
    @(negedge clkin);
    dll_lock = 1'b1;
    wait_for(0, 200, n);
    check("recover_init", int'(n > 0), 1);

    // Asynchronous reset between clock edges.
    @(posedge clkin);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_vec", int'(act_vec), int'(RST_VEC));
    repeat (2) @(negedge clkin);
    rst_n = 1'b1;

    // Randomised soak against the model.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clkin);
      pll_lock = ($urandom_range(0, 399) != 0);
      dll_lock = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 9) == 0) upd_req = ~upd_req;
    end

    repeat (3) @(negedge clkin);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
